// File: rtl/trailing_one_iter.sv
// Sequential set-bit iterator: captures a vector and emits the index of each set bit, one per
// accepted beat, lowest-first (MSB_FIRST=0) or highest-first (MSB_FIRST=1).
// Optional feature macro: TRAILING_ONE_ITER_COUNT_EN adds o_remain (beats left incl. current).
module trailing_one_iter #(
  parameter int unsigned DATA_WD   = 8,
  parameter int unsigned IND_WD    = (DATA_WD > 1) ? $clog2(DATA_WD) : 1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [DATA_WD-1:0] i_a,
  output logic               o_ready,
  output logic               o_valid,
  output logic [IND_WD-1:0]  o_index,
  output logic               o_last,
  input  logic               i_ready,
`ifdef TRAILING_ONE_ITER_COUNT_EN
  output logic [IND_WD:0]    o_remain,
`endif
  output logic               o_none
);

  localparam logic StIdle = 1'b0;
  localparam logic StScan = 1'b1;

  localparam logic [DATA_WD-1:0] VecOne = DATA_WD'(1);

  logic               st_q, st_d;
  logic [DATA_WD-1:0] vec_q, vec_d;
  logic               none_q, none_d;

  logic [DATA_WD-1:0] vec_rev, sel_rev, sel;
  logic [IND_WD-1:0]  idx;
  logic               last;
  logic               load, beat;

  // Pick the one-hot of the next bit to emit; MSB-first isolates the lowest bit of the
  // bit-reversed vector and reverses it back.
  always_comb begin
    vec_rev = '0;
    sel_rev = '0;
    sel     = '0;
    for (int i = 0; i < int'(DATA_WD); i++) begin
      vec_rev[i] = vec_q[int'(DATA_WD) - 1 - i];
    end
    if (MSB_FIRST) begin
      sel_rev = vec_rev & (~vec_rev + VecOne);
      for (int i = 0; i < int'(DATA_WD); i++) begin
        sel[i] = sel_rev[int'(DATA_WD) - 1 - i];
      end
    end else begin
      sel = vec_q & (~vec_q + VecOne);
    end
  end

  // Binary-encode the one-hot selection; only real bit positions contribute.
  always_comb begin
    idx = '0;
    for (int i = 0; i < int'(DATA_WD); i++) begin
      if (sel[i]) begin
        idx = idx | IND_WD'(i);
      end
    end
  end

  // Handshake decode and outputs, all derived from registered state.
  always_comb begin
    load    = (st_q == StIdle) && i_valid;
    beat    = (st_q == StScan) && i_ready;
    last    = (vec_q == sel);
    o_ready = (st_q == StIdle);
    o_valid = (st_q == StScan);
    o_index = (st_q == StScan) ? idx : '0;
    o_last  = (st_q == StScan) && last;
    o_none  = none_q;
  end

  // Next-state: load a non-zero vector, flag an all-zero one, clear each emitted bit.
  always_comb begin
    st_d   = st_q;
    vec_d  = vec_q;
    none_d = 1'b0;
    if (load) begin
      if (|i_a) begin
        vec_d = i_a;
        st_d  = StScan;
      end else begin
        none_d = 1'b1;
      end
    end else if (beat) begin
      vec_d = vec_q & ~sel;
      if (last) begin
        st_d = StIdle;
      end
    end
  end

  // State registers; reset drops any remaining bits of an in-flight vector.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q   <= StIdle;
      vec_q  <= '0;
      none_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      vec_q  <= vec_d;
      none_q <= none_d;
    end
  end

`ifdef TRAILING_ONE_ITER_COUNT_EN
  logic [IND_WD:0] cnt_q, cnt_d, pop;

  // Popcount of the incoming vector, loaded on accept and counted down per beat.
  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(DATA_WD); i++) begin
      pop = pop + {{IND_WD{1'b0}}, i_a[i]};
    end
    cnt_d = cnt_q;
    if (load && (|i_a)) begin
      cnt_d = pop;
    end else if (beat) begin
      cnt_d = cnt_q - {{IND_WD{1'b0}}, 1'b1};
    end
    o_remain = cnt_q;
  end

  // Remaining-beat counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_trailing_one_iter.sv
// Self-checking bench for trailing_one_iter: LSB-first and MSB-first instances share stimulus
// and are compared every cycle against a queue-based model of the pending set-bit indices.
module tb_trailing_one_iter;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic [7:0] i_a;
  logic       i_ready;

  logic       l_ready, l_valid, l_last, l_none;
  logic [2:0] l_index;
  logic       m_ready, m_valid, m_last, m_none;
  logic [2:0] m_index;
`ifdef TRAILING_ONE_ITER_COUNT_EN
  logic [3:0] l_remain, m_remain;
`endif

  int n_vec = 0;
  int n_err = 0;

  int q_l[$];
  int q_m[$];
  bit exp_none = 1'b0;

  always #5 clk = ~clk;

  trailing_one_iter #(.DATA_WD(8), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_a     (i_a),
    .o_ready (l_ready),
    .o_valid (l_valid),
    .o_index (l_index),
    .o_last  (l_last),
    .i_ready (i_ready),
`ifdef TRAILING_ONE_ITER_COUNT_EN
    .o_remain(l_remain),
`endif
    .o_none  (l_none)
  );

  trailing_one_iter #(.DATA_WD(8), .MSB_FIRST(1'b1)) u_msb (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_a     (i_a),
    .o_ready (m_ready),
    .o_valid (m_valid),
    .o_index (m_index),
    .o_last  (m_last),
    .i_ready (i_ready),
`ifdef TRAILING_ONE_ITER_COUNT_EN
    .o_remain(m_remain),
`endif
    .o_none  (m_none)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, compare outputs, then advance the model
  // by what the coming rising edge will do.
  task automatic step(input logic rst, input logic v, input logic [7:0] a, input logic rdy);
    int n;
    @(negedge clk);
    i_rst   = rst;
    i_valid = v;
    i_a     = a;
    i_ready = rdy;
    n = q_l.size();
    check("lsb_ready", 32'(l_ready), 32'(n == 0));
    check("lsb_valid", 32'(l_valid), 32'(n != 0));
    check("lsb_index", 32'(l_index), (n != 0) ? q_l[0] : 0);
    check("lsb_last",  32'(l_last),  32'(n == 1));
    check("lsb_none",  32'(l_none),  32'(exp_none));
    check("msb_ready", 32'(m_ready), 32'(n == 0));
    check("msb_valid", 32'(m_valid), 32'(n != 0));
    check("msb_index", 32'(m_index), (n != 0) ? q_m[0] : 0);
    check("msb_last",  32'(m_last),  32'(n == 1));
    check("msb_none",  32'(m_none),  32'(exp_none));
`ifdef TRAILING_ONE_ITER_COUNT_EN
    check("lsb_remain", 32'(l_remain), n);
    check("msb_remain", 32'(m_remain), n);
`endif
    if (rst) begin
      q_l.delete();
      q_m.delete();
      exp_none = 1'b0;
    end else if (n == 0) begin
      exp_none = v && (a == 8'h00);
      if (v && (a != 8'h00)) begin
        for (int i = 0; i < 8; i++) if (a[i]) q_l.push_back(i);
        for (int i = 7; i >= 0; i--) if (a[i]) q_m.push_back(i);
      end
    end else begin
      exp_none = 1'b0;
      if (rdy) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
    end
  endtask

  task automatic drain(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_a     = 8'h00;
    i_ready = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);

    // Reset state, then the mixed vector: LSB 1,2,5,7 / MSB 7,5,2,1.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'b1010_0110, 1'b1);
    step(1'b0, 1'b1, 8'hFF, 1'b1);   // ignored during SCAN
    drain(5);

    // Backpressure on 8'h81: hold three cycles, then both beats back-to-back.
    step(1'b0, 1'b1, 8'h81, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    drain(3);

    // Zero vector pulses o_none; single high bit; all-ones.
    step(1'b0, 1'b1, 8'h00, 1'b1);
    drain(2);
    step(1'b0, 1'b1, 8'h80, 1'b1);
    drain(2);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    drain(10);
    step(1'b0, 1'b1, 8'b0110_1001, 1'b1);
    drain(6);

    // Reset for two cycles in the middle of an all-ones scan.
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    drain(4);

    // Randomized traffic with occasional zero vectors, stalls and resets.
    for (int k = 0; k < 400; k++) begin
      logic [7:0] a;
      logic       v, r, rs;
      a  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      v  = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 60) == 0);
      step(rs, v, a, r);
    end
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
